// File: rtl/counter_event_monitor_if.sv
// Event port between counter_event_monitor and its consumer.
// Head event is packed as {type[1:0], dir, 1'b0, value[3:0]}.
interface counter_event_monitor_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_data;

  modport master (
    output ev_valid,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_data,
    output ev_ready
  );
endinterface

// File: rtl/counter_event_monitor.sv
// Watches a 4-bit up/down counter; queues wrap (and optional step) events.
// Step checking is compiled in with COUNT_MON_STEP_CHECK_EN.
module counter_event_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   count,
  input  logic                         mode,
  counter_event_monitor_if.master      ev,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [STAT_W-1:0]            wrap_cnt,
  output logic [STAT_W-1:0]            err_cnt,
  output logic [STAT_W-1:0]            drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [STAT_W-1:0] SAT  = '1;
  localparam logic [STAT_W-1:0] SONE = STAT_W'(1);

  logic [3:0]        prev_count_q;
  logic              prev_mode_q;
  logic              prev_valid_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       level_q, level_d;
  logic [STAT_W-1:0] wrap_q, wrap_d;
  logic [STAT_W-1:0] drop_q, drop_d;

  logic       ovf, unf, step_err, wrap, det;
  logic       pop, push, drop, full;
  logic [1:0] ev_type;
  logic [7:0] ev_word;

  assign ovf = prev_valid_q & prev_mode_q
             & (prev_count_q == 4'hF) & (count == 4'h0);
  assign unf = prev_valid_q & ~prev_mode_q
             & (prev_count_q == 4'h0) & (count == 4'hF);
  assign wrap = ovf | unf;

`ifdef COUNT_MON_STEP_CHECK_EN
  logic [3:0]        exp_val;
  logic [STAT_W-1:0] err_q, err_d;

  assign exp_val = prev_mode_q ? prev_count_q + 4'd1
                               : prev_count_q - 4'd1;
  // A wrap always equals exp_val, so STEP never overlaps OVF/UNF.
  assign step_err = prev_valid_q & (count != exp_val);

  always_comb begin
    err_d = err_q;
    if (step_err && err_q != SAT) err_d = err_q + SONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign step_err = 1'b0;
  assign err_cnt  = '0;
`endif

  assign det     = wrap | step_err;
  assign ev_type = step_err ? 2'b10 : (unf ? 2'b01 : 2'b00);
  assign ev_word = {ev_type, prev_mode_q, 1'b0, count};

  assign full = (level_q == FULL);
  assign pop  = ev.ev_valid & ev.ev_ready;
  assign push = det & (~full | pop);
  assign drop = det & full & ~pop;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    wrap_d = wrap_q;
    drop_d = drop_q;
    if (wrap && wrap_q != SAT) wrap_d = wrap_q + SONE;
    if (drop && drop_q != SAT) drop_d = drop_q + SONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_count_q <= '0;
      prev_mode_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      wrap_q       <= '0;
      drop_q       <= '0;
    end else begin
      prev_count_q <= count;
      prev_mode_q  <= mode;
      prev_valid_q <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q      <= level_d;
      wrap_q       <= wrap_d;
      drop_q       <= drop_d;
    end
  end

  // Storage needs no reset; ev_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ev_word;
  end

  assign ev.ev_valid = (level_q != '0);
  assign ev.ev_data  = ev.ev_valid ? mem_q[rptr_q] : 8'h00;
  assign fifo_level  = level_q;
  assign wrap_cnt    = wrap_q;
  assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_counter_event_monitor.sv
// Randomized and directed bench for counter_event_monitor.
// Queue-based reference model; all outputs compared every cycle.
module tb_counter_event_monitor;
  localparam int DEPTH = 4;
  localparam int SW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int SMAX  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    count = 4'd0;
  logic          mode = 1'b0;
  logic [LW-1:0] fifo_level;
  logic [SW-1:0] wrap_cnt, err_cnt, drop_cnt;

  counter_event_monitor_if ev_if ();

  counter_event_monitor #(
    .FIFO_DEPTH(DEPTH),
    .STAT_W    (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .mode      (mode),
    .ev        (ev_if),
    .fifo_level(fifo_level),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit       m_pv;
  int       m_pc;
  bit       m_pm;
  bit [7:0] q[$];
  int       m_wrap, m_err, m_drop;

`ifdef COUNT_MON_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    m_pv = 0; m_pc = 0; m_pm = 0;
    q.delete();
    m_wrap = 0; m_err = 0; m_drop = 0;
  endtask

  task automatic check_all();
    chk("ev_valid", int'(ev_if.ev_valid), int'(q.size() > 0));
    chk("ev_data", int'(ev_if.ev_data), q.size() > 0 ? int'(q[0]) : 0);
    chk("fifo_level", int'(fifo_level), q.size());
    chk("wrap_cnt", int'(wrap_cnt), m_wrap);
    chk("err_cnt", int'(err_cnt), m_err);
    chk("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  // Called at a negedge with inputs set; ends at the next negedge.
  task automatic cyc();
    bit       pop;
    bit       has;
    bit       is_wrap;
    bit       is_step;
    int       c;
    int       nxt;
    bit [7:0] e;
    c   = int'(count);
    pop = (q.size() > 0) && ev_if.ev_ready;
    has = 0; is_wrap = 0; is_step = 0; e = 8'h00;
    if (m_pv) begin
      nxt = m_pm ? (m_pc + 1) % 16 : (m_pc + 15) % 16;
      if (m_pm && m_pc == 15 && c == 0) begin
        has = 1; is_wrap = 1; e = {2'b00, 1'b1, 1'b0, count};
      end else if (!m_pm && m_pc == 0 && c == 15) begin
        has = 1; is_wrap = 1; e = {2'b01, 1'b0, 1'b0, count};
      end else if (STEP_EN && c != nxt) begin
        has = 1; is_step = 1; e = {2'b10, m_pm, 1'b0, count};
      end
    end
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (has) begin
      if (q.size() < DEPTH) q.push_back(e);
      else if (m_drop < SMAX) m_drop++;
    end
    if (is_wrap && m_wrap < SMAX) m_wrap++;
    if (is_step && m_err < SMAX) m_err++;
    m_pc = c; m_pm = mode; m_pv = 1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drive(input int c, input bit m, input bit r);
    count = 4'(c);
    mode = m;
    ev_if.ev_ready = r;
    cyc();
  endtask

  // Asynchronous assertion mid-cycle; ends at a negedge with rst low.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("rst_valid", int'(ev_if.ev_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    bit m;
    ev_if.ev_ready = 1'b0;
    model_clear();
    @(negedge clk);
    chk("por_valid", int'(ev_if.ev_valid), 0);
    chk("por_data", int'(ev_if.ev_data), 0);
    check_all();
    rst = 1'b0;

    // Up wrap
    drive(13, 1, 1);
    drive(14, 1, 1);
    drive(15, 1, 1);
    drive(0, 1, 1);
    chk("up_data", int'(ev_if.ev_data), 8'h20);
    chk("up_wrap", int'(wrap_cnt), 1);
    drive(1, 1, 1);
    chk("up_drop", int'(drop_cnt), 0);

    // Down wrap
    do_reset();
    drive(1, 0, 1);
    drive(0, 0, 1);
    drive(15, 0, 1);
    chk("dn_data", int'(ev_if.ev_data), 8'h4F);
    chk("dn_wrap", int'(wrap_cnt), 1);
    drive(14, 0, 1);

    // Backpressure: six wraps, then full push with pop
    do_reset();
    drive(15, 1, 0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(0, 0, 0);
      else drive(15, 1, 0);
    end
    chk("bp_level", int'(fifo_level), 4);
    chk("bp_drop", int'(drop_cnt), 2);
    chk("bp_wrap", int'(wrap_cnt), 6);
    chk("bp_head", int'(ev_if.ev_data), 8'h20);
    drive(0, 1, 1);
    chk("pp_level", int'(fifo_level), 4);
    chk("pp_drop", int'(drop_cnt), 2);
    chk("pp_head", int'(ev_if.ev_data), 8'h4F);
    for (int i = 1; i <= 5; i++) drive(i, 1, 1);
    chk("drain_level", int'(fifo_level), 0);

    // Step error
    do_reset();
    drive(5, 1, 1);
    drive(7, 1, 1);
    chk("step_valid", int'(ev_if.ev_valid), int'(STEP_EN));
    chk("step_err", int'(err_cnt), int'(STEP_EN));
    if (STEP_EN) chk("step_data", int'(ev_if.ev_data), 8'hA7);
    drive(8, 1, 1);

    // Reset with events queued; wrap across reset is ignored
    do_reset();
    drive(0, 0, 0);
    drive(15, 1, 0);
    drive(0, 0, 0);
    drive(15, 1, 0);
    chk("pre_rst_level", int'(fifo_level), 3);
    do_reset();
    chk("mid_rst_wrap", int'(wrap_cnt), 0);
    drive(0, 1, 0);
    chk("post_rst_valid", int'(ev_if.ev_valid), 0);
    chk("post_rst_wrap", int'(wrap_cnt), 0);

    // Saturation of wrap and drop counters
    do_reset();
    drive(15, 1, 0);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) drive(0, 0, 0);
      else drive(15, 1, 0);
    end
    chk("sat_wrap", int'(wrap_cnt), SMAX);
    chk("sat_drop", int'(drop_cnt), SMAX);

    // Randomized counter behaviour with glitches and random ready
    do_reset();
    c = int'($urandom_range(15));
    m = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) m = ~m;
      if ($urandom_range(7) == 0) c = int'($urandom_range(15));
      drive(c, m, 1'(($urandom_range(3) != 0)));
      c = m ? (c + 1) % 16 : (c + 15) % 16;
      if (i % 1000 == 999) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_event_monitor.md
# counter_event_monitor

Downstream consumer of the 4-bit up/down counter. Samples `count` and `mode` every clock and detects overflow wraps (15→0 while counting up) and underflow wraps (0→15 while counting down). With step checking compiled in, it also detects illegal steps. Detected events are queued in a small FIFO and drained through a valid/ready port, alongside saturating statistics counters for the scoreboard and status logic.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event FIFO entries; a power of two, at least 2.
- `STAT_W`, default 8: width of each statistics counter.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `count`  input  4: counter value under observation.
- `mode`  input  1: counter direction; 1 = up, 0 = down.
- `ev_valid`  output  1: FIFO head holds an event.
- `ev_ready`  input  1: consumer accepts the head event.
- `ev_data`  output  8: head event, packed as {type[1:0], dir, 1'b0, value[3:0]}.
- `fifo_level`  output  $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- `wrap_cnt`  output  STAT_W: total overflow plus underflow events; saturates.
- `err_cnt`  output  STAT_W: total step-error events; saturates.
- `drop_cnt`  output  STAT_W: events lost because the FIFO was full; saturates.

## Operation
- Sampling:
  - Sample n is taken at edge n into `prev_count`/`prev_mode`.
  - A `prev_valid` flag sets after the first sample following reset.
  - No event is evaluated while `prev_valid` = 0.
- Expected value: exp = `prev_mode` ? `prev_count`+1 : `prev_count`−1, computed modulo 16. The counter applies the direction sampled one edge before the new value appears.
- Classification, evaluated only when `prev_valid` = 1; the three types are mutually exclusive:
  - type 00 OVF: `prev_mode`=1, `prev_count`=15, `count`=0.
  - type 01 UNF: `prev_mode`=0, `prev_count`=0, `count`=15.
  - type 10 STEP: `count` ≠ exp (only if step checking is enabled).
  - type 11: reserved, never generated.
- Event fields:
  - dir = `prev_mode`.
  - value = `count` (the sample that triggered the event).
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full (pop frees the slot the push uses).
  - Push while full with no pop: the event is dropped and `drop_cnt` increments.
  - `ev_data` is stable while `ev_valid`=1 and `ev_ready`=0.
- Statistics:
  - `wrap_cnt` and `err_cnt` increment on detection, even if the event is dropped.
  - All counters saturate at 2^STAT_W−1; no wrap.
- Reset mid-operation clears the FIFO, statistics and `prev_valid` immediately; any in-flight event is discarded.

## Timing
- Reset values:
  - `ev_valid`=0, `ev_data`=0, `fifo_level`=0.
  - `wrap_cnt`=0, `err_cnt`=0, `drop_cnt`=0.
  - `prev_valid`=0.
- Detection latency: an event found at edge n is pushed at edge n. `ev_valid` is high from after edge n; there is no combinational fall-through.
- Pop: occurs at an edge where `ev_valid`=1 and `ev_ready`=1. The next entry is presented after that edge.
- Statistics update at the detection edge and are visible after it.
- First comparison after reset release is at the second sampling edge.

## Configuration
- Macro: `COUNT_MON_STEP_CHECK_EN`.
- Defined:
  - STEP detection is active and `err_cnt` counts.
  - A step of 0 (counter stalled) or of ±2 or more is a STEP event.
- Undefined:
  - STEP logic is absent.
  - `err_cnt` is tied to 0.
  - Non-wrap mismatches are ignored; OVF/UNF detection is unchanged.

## Test plan
- Up wrap: `mode`=1, `count` sweeps 13,14,15,0,1; `ev_ready`=1 → one event `ev_data`=8'h20, `wrap_cnt`=1, `drop_cnt`=0.
- Down wrap: `mode`=0, `count` sweeps 1,0,15,14 → event `ev_data`=8'h4F, `wrap_cnt`=1.
- Backpressure: `ev_ready`=0, six wraps with FIFO_DEPTH=4 → `fifo_level`=4, `drop_cnt`=2, `wrap_cnt`=6. Then `ev_ready`=1 → four events drain in order, one per cycle.
- Full plus simultaneous push/pop: FIFO full, `ev_ready`=1 on a wrap cycle → `fifo_level` stays 4, `drop_cnt` unchanged.
- Step error (macro defined): `mode`=1, `count` 5→7 → `ev_data`=8'hA7, `err_cnt`=1. Same stimulus with the macro undefined → no event, `err_cnt`=0.
- Reset mid-operation: `rst` pulsed with 3 events queued → `ev_valid`=0 and all counters 0 immediately. A wrap on the first sample after reset release is not reported.
